// File: rtl/decode_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_trace_pkg
// Description : Shared types for the LC-3 decode trace capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_trace_pkg;

    localparam int unsigned c_instr_w = 16;
    localparam int unsigned c_npc_w   = 16;
    localparam int unsigned c_e_w     = 6;
    localparam int unsigned c_w_w     = 2;

    typedef enum logic [1:0] {
        S_HOLDOFF = 2'd0,
        S_RUN     = 2'd1,
        S_FROZEN  = 2'd2
    } state_t;

    // Declared MSB first, so instr occupies the least significant bits.
    typedef struct packed {
        logic                 mem;
        logic [c_w_w-1:0]     w;
        logic [c_e_w-1:0]     e;
        logic [c_npc_w-1:0]   npc;
        logic [c_instr_w-1:0] instr;
    } decode_rec_t;

    function automatic int unsigned rec_width();
        return $bits(decode_rec_t);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Synchronous FIFO with a registered head and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned c_ptr_w = LVL_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0] wr_q;
    logic [LVL_W-1:0] rd_q;
    logic [LVL_W-1:0] rd_d;
    logic [LVL_W-1:0] w_level;
    logic             w_do_push;
    logic             w_do_pop;
    logic             valid_q;
    logic [WIDTH-1:0] dout_q;

    assign w_level   = wr_q - rd_q;
    assign w_do_pop  = pop_i && valid_q;
    assign w_do_push = push_i && (!w_level[c_ptr_w] || w_do_pop);
    assign rd_d      = rd_q + {{c_ptr_w{1'b0}}, w_do_pop};

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            mem_q[wr_q[c_ptr_w-1:0]] <= din_i;
        end
    end

    // The head only sees entries present before this edge, giving one cycle
    // of push-to-valid latency and no write/read collision on the same slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            if (w_do_push) begin
                wr_q <= wr_q + LVL_W'(1);
            end
            rd_q    <= rd_d;
            valid_q <= (w_level != {{c_ptr_w{1'b0}}, w_do_pop});
            dout_q  <= mem_q[rd_d[c_ptr_w-1:0]];
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = dout_q;
    assign full_o  = w_level[c_ptr_w];
    assign empty_o = (w_level == '0);
    assign level_o = w_level;

endmodule
`default_nettype wire

// File: rtl/decode_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : decode_trace_capture
// Description : Holdoff-gated, optionally change-filtered capture of LC-3
//               decode outputs into a FIFO drained over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_trace_capture
    import decode_trace_pkg::*;
#(
    parameter int unsigned INSTR_W      = 16,
    parameter int unsigned NPC_W        = 16,
    parameter int unsigned E_W          = 6,
    parameter int unsigned W_W          = 2,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned HOLDOFF      = 7,
    parameter bit          STOP_ON_FULL = 1'b0,
    parameter int unsigned OVF_W        = 16,
    localparam int unsigned REC_W = INSTR_W + NPC_W + E_W + W_W + 1,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_en,
    input  logic               change_only,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_dout,
    input  logic [NPC_W-1:0]   npc_in,
    input  logic [E_W-1:0]     E_control,
    input  logic [W_W-1:0]     W_control,
    input  logic               Mem_control,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REC_W-1:0]   out_data,
    output logic [LVL_W-1:0]   level,
    output logic [OVF_W-1:0]   drop_count,
    output logic               frozen
);

    localparam int unsigned c_cnt_w = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        (HOLDOFF > 0) ? c_cnt_w'(HOLDOFF - 1) : '0;

    state_t             state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic [REC_W-1:0]   last_q;
    logic               last_vld_q;
    logic [OVF_W-1:0]   drop_q;
    logic               frozen_q;

    logic [REC_W-1:0]   w_rec;
    logic               w_clear;
    logic               w_attempt;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;

    assign w_rec   = {Mem_control, W_control, E_control, npc_in, instr_dout};
    assign w_clear = clear && (state_q != S_HOLDOFF);
    assign w_pop   = out_valid && out_ready && !w_empty;

    assign w_attempt = (state_q == S_RUN) && sample_en && !w_clear &&
                       (!change_only || !last_vld_q || (w_rec != last_q));
    assign w_push    = w_attempt && (!w_full || w_pop);
    assign w_drop    = w_attempt && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_HOLDOFF;
            cnt_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            drop_q     <= '0;
            frozen_q   <= 1'b0;
        end else begin
            case (state_q)
                S_HOLDOFF: begin
                    cnt_q <= cnt_q + c_cnt_w'(1);
                    if ((HOLDOFF == 0) || (cnt_q == c_cnt_last)) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN, S_FROZEN: begin
                    if (w_clear) begin
                        state_q    <= S_RUN;
                        frozen_q   <= 1'b0;
                        drop_q     <= '0;
                        last_vld_q <= 1'b0;
                    end else begin
                        if (w_push) begin
                            last_q     <= w_rec;
                            last_vld_q <= 1'b1;
                        end
                        if (w_drop) begin
                            if (drop_q != '1) begin
                                drop_q <= drop_q + OVF_W'(1);
                            end
                            if (STOP_ON_FULL) begin
                                state_q  <= S_FROZEN;
                                frozen_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_HOLDOFF;
                end
            endcase
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (w_clear),
        .push_i  (w_push),
        .din_i   (w_rec),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .dout_o  (out_data),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level)
    );

    assign drop_count = drop_q;
    assign frozen     = frozen_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_trace_capture
// Description : Directed bench for decode_trace_capture (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_trace_capture;
    import decode_trace_pkg::*;

    localparam int REC_W = rec_width();

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sample_en = 1'b0, change_only = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic [15:0] instr_dout = '0, npc_in = '0;
    logic [5:0]  E_control = '0;
    logic [1:0]  W_control = '0;
    logic        Mem_control = 1'b0;

    logic             ov0, ov1, ov2;
    logic [REC_W-1:0] od0, od1, od2;
    logic [3:0]       lv0, lv1;
    logic [1:0]       lv2;
    logic [15:0]      dc0, dc1;
    logic [1:0]       dc2;
    logic             fz0, fz1, fz2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    decode_trace_capture #(.STOP_ON_FULL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .sample_en(sample_en), .change_only(change_only),
        .clear(clear), .instr_dout(instr_dout), .npc_in(npc_in), .E_control(E_control),
        .W_control(W_control), .Mem_control(Mem_control), .out_valid(ov0),
        .out_ready(out_ready), .out_data(od0), .level(lv0), .drop_count(dc0), .frozen(fz0));

    decode_trace_capture #(.STOP_ON_FULL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .sample_en(sample_en), .change_only(change_only),
        .clear(clear), .instr_dout(instr_dout), .npc_in(npc_in), .E_control(E_control),
        .W_control(W_control), .Mem_control(Mem_control), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1), .level(lv1), .drop_count(dc1), .frozen(fz1));

    decode_trace_capture #(.DEPTH(2), .HOLDOFF(0), .STOP_ON_FULL(1'b0), .OVF_W(2)) dut2 (
        .clock(clock), .reset(reset), .sample_en(sample_en), .change_only(change_only),
        .clear(clear), .instr_dout(instr_dout), .npc_in(npc_in), .E_control(E_control),
        .W_control(W_control), .Mem_control(Mem_control), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2), .level(lv2), .drop_count(dc2), .frozen(fz2));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; sample_en = 1'b0; change_only = 1'b0; clear = 1'b0; out_ready = 1'b0;
        instr_dout = '0; npc_in = '0; E_control = '0; W_control = '0; Mem_control = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // After this, dut0/dut1 are in RUN and the next edge is their first sample.
    task automatic run_holdoff();
        reset_dut();
        repeat (7) step();
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ov0); end
        vectors++; if (od0 !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", od0); end
        vectors++; if (lv0 !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", lv0); end
        vectors++; if (dc0 !== 16'd0) begin miscompares++; $display("FAIL reset_drop: got %0d want 0", dc0); end
        vectors++; if (fz1 !== 1'b0) begin miscompares++; $display("FAIL reset_frozen: got %b want 0", fz1); end
    endtask

    task automatic test_holdoff();
        logic [1:0] exp_lv2, exp_dc2;
        reset = 1'b1; sample_en = 1'b1; instr_dout = 16'h1234;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            vectors++; if (ov0 !== (e >= 9)) begin miscompares++; $display("FAIL holdoff_valid e%0d: got %b want %b", e, ov0, (e >= 9)); end
            if (e <= 7) begin
                vectors++; if (lv0 !== 4'd0) begin miscompares++; $display("FAIL holdoff_level e%0d: got %0d want 0", e, lv0); end
            end
            exp_lv2 = (e == 1) ? 2'd0 : ((e == 2) ? 2'd1 : 2'd2);
            exp_dc2 = (e <= 3) ? 2'd0 : ((e >= 6) ? 2'd3 : 2'(e - 3));
            vectors++; if (lv2 !== exp_lv2) begin miscompares++; $display("FAIL h0_level e%0d: got %0d want %0d", e, lv2, exp_lv2); end
            vectors++; if (dc2 !== exp_dc2) begin miscompares++; $display("FAIL h0_drop_sat e%0d: got %0d want %0d", e, dc2, exp_dc2); end
            vectors++; if (ov2 !== (e >= 3)) begin miscompares++; $display("FAIL h0_valid e%0d: got %b want %b", e, ov2, (e >= 3)); end
        end
        vectors++; if (od0 !== 41'h1234) begin miscompares++; $display("FAIL holdoff_data: got %h want 1234", od0); end
        vectors++; if (lv0 !== 4'd2) begin miscompares++; $display("FAIL holdoff_level2: got %0d want 2", lv0); end
        vectors++; if (od2 !== 41'h1234) begin miscompares++; $display("FAIL h0_data: got %h want 1234", od2); end
        vectors++; if (fz2 !== 1'b0) begin miscompares++; $display("FAIL h0_frozen: got %b want 0", fz2); end
        sample_en = 1'b0;
    endtask

    task automatic test_packing();
        run_holdoff();
        instr_dout = 16'hA5A5; npc_in = 16'h3001; E_control = 6'h2A; W_control = 2'b10; Mem_control = 1'b1;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        step();
        vectors++; if (ov0 !== 1'b1) begin miscompares++; $display("FAIL pack_valid: got %b want 1", ov0); end
        vectors++; if (od0 !== 41'h1AA_3001_A5A5) begin miscompares++; $display("FAIL pack_data: got %h want 1aa3001a5a5", od0); end
    endtask

    task automatic test_change_only();
        run_holdoff();
        change_only = 1'b1; sample_en = 1'b1; instr_dout = 16'h1000;
        repeat (3) step();
        instr_dout = 16'h2000;
        step();
        sample_en = 1'b0;
        step();
        vectors++; if (lv0 !== 4'd2) begin miscompares++; $display("FAIL chg_level: got %0d want 2", lv0); end
        vectors++; if (od0 !== 41'h1000) begin miscompares++; $display("FAIL chg_head0: got %h want 1000", od0); end
        out_ready = 1'b1;
        step();
        vectors++; if (ov0 !== 1'b1 || od0 !== 41'h2000) begin miscompares++; $display("FAIL chg_head1: got v%b %h want v1 2000", ov0, od0); end
        step();
        vectors++; if (ov0 !== 1'b0 || lv0 !== 4'd0) begin miscompares++; $display("FAIL chg_drain: got v%b lvl %0d want v0 lvl 0", ov0, lv0); end
        out_ready = 1'b0; change_only = 1'b0;
    endtask

    task automatic test_overflow();
        run_holdoff();
        sample_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            instr_dout = 16'h0100 + 16'(i);
            step();
            if (i == 8) begin
                vectors++; if (fz1 !== 1'b1 || dc1 !== 16'd1) begin miscompares++; $display("FAIL stop_freeze: got fz %b drop %0d want fz 1 drop 1", fz1, dc1); end
            end
        end
        sample_en = 1'b0;
        vectors++; if (lv0 !== 4'd8 || dc0 !== 16'd4 || fz0 !== 1'b0) begin miscompares++; $display("FAIL ovf_run: got lvl %0d drop %0d fz %b want 8 4 0", lv0, dc0, fz0); end
        vectors++; if (lv1 !== 4'd8 || dc1 !== 16'd1 || fz1 !== 1'b1) begin miscompares++; $display("FAIL ovf_stop: got lvl %0d drop %0d fz %b want 8 1 1", lv1, dc1, fz1); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            vectors++; if (ov0 !== 1'b1 || od0 !== {25'd0, 16'h0100 + 16'(j)}) begin miscompares++; $display("FAIL ovf_order0 %0d: got v%b %h", j, ov0, od0); end
            vectors++; if (ov1 !== 1'b1 || od1 !== {25'd0, 16'h0100 + 16'(j)}) begin miscompares++; $display("FAIL ovf_order1 %0d: got v%b %h", j, ov1, od1); end
            step();
        end
        out_ready = 1'b0;
        vectors++; if (lv1 !== 4'd4 || fz1 !== 1'b1) begin miscompares++; $display("FAIL frozen_pop: got lvl %0d fz %b want 4 1", lv1, fz1); end
        clear = 1'b1; sample_en = 1'b1; instr_dout = 16'hCAFE;
        step();
        clear = 1'b0; instr_dout = 16'hBEEF;
        vectors++; if (lv1 !== 4'd0 || dc1 !== 16'd0 || fz1 !== 1'b0) begin miscompares++; $display("FAIL clear1: got lvl %0d drop %0d fz %b want 0 0 0", lv1, dc1, fz1); end
        vectors++; if (lv0 !== 4'd0 || dc0 !== 16'd0 || ov0 !== 1'b0) begin miscompares++; $display("FAIL clear0: got lvl %0d drop %0d v %b want 0 0 0", lv0, dc0, ov0); end
        step();
        sample_en = 1'b0;
        step();
        vectors++; if (lv1 !== 4'd1 || ov1 !== 1'b1 || od1 !== 41'hBEEF) begin miscompares++; $display("FAIL resume: got lvl %0d v %b %h want 1 1 beef", lv1, ov1, od1); end
    endtask

    task automatic test_back_to_back();
        run_holdoff();
        sample_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr_dout = 16'h0200 + 16'(i);
            step();
        end
        vectors++; if (lv0 !== 4'd8 || ov0 !== 1'b1) begin miscompares++; $display("FAIL b2b_fill: got lvl %0d v %b want 8 1", lv0, ov0); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr_dout = 16'h0208 + 16'(k);
            vectors++; if (od0 !== {25'd0, 16'h0200 + 16'(k)}) begin miscompares++; $display("FAIL b2b_head %0d: got %h", k, od0); end
            step();
            vectors++; if (lv0 !== 4'd8 || dc0 !== 16'd0) begin miscompares++; $display("FAIL b2b_level %0d: got lvl %0d drop %0d want 8 0", k, lv0, dc0); end
        end
        sample_en = 1'b0;
        for (int k = 8; k < 16; k++) begin
            vectors++; if (ov0 !== 1'b1 || od0 !== {25'd0, 16'h0200 + 16'(k)}) begin miscompares++; $display("FAIL b2b_wrap %0d: got v%b %h", k, ov0, od0); end
            step();
        end
        vectors++; if (lv0 !== 4'd0 || ov0 !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got lvl %0d v %b want 0 0", lv0, ov0); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_holdoff();
        sample_en = 1'b1; instr_dout = 16'h7777;
        repeat (3) step();
        reset = 1'b1;
        step();
        vectors++; if (ov0 !== 1'b0 || od0 !== '0 || lv0 !== 4'd0) begin miscompares++; $display("FAIL midreset: got v%b %h lvl %0d want 0 0 0", ov0, od0, lv0); end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) begin
                vectors++; if (lv0 !== 4'd0) begin miscompares++; $display("FAIL midreset_holdoff: got %0d want 0", lv0); end
            end
        end
        vectors++; if (lv0 !== 4'd1) begin miscompares++; $display("FAIL midreset_resume: got %0d want 1", lv0); end
        sample_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_packing();
        test_change_only();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_trace_capture.md
Name: decode_trace_capture

Overview:
- Synthesizable capture buffer for the LC-3 decode-stage outputs: instr_dout, npc_in, E_control, W_control and Mem_control.
- After a programmable post-reset holdoff, it samples qualified decode outputs into a parametrised FIFO. Optionally it captures only when the record changes.
- The FIFO drains through a valid/ready port to a debug reader or the bench. It sits beside the decode stage and does not alter its outputs.

Parameters:
- INSTR_W, 16, instruction width
- NPC_W, 16, next-PC width
- E_W, 6, E_control width
- W_W, 2, W_control width
- DEPTH, 8, FIFO entries; power of two, >=2
- HOLDOFF, 7, clock cycles after reset deassertion before sampling starts
- STOP_ON_FULL, 0, 1 = freeze capture on first dropped record; 0 = drop and keep running
- OVF_W, 16, drop-counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- sample_en  in  1  decode output qualifier; sample only when 1
- change_only  in  1  1 = capture only if record differs from last captured record
- clear  in  1  one-cycle pulse: flush FIFO, zero drop_count, leave FROZEN
- instr_dout  in  INSTR_W  decode instruction
- npc_in  in  NPC_W  decode next PC
- E_control  in  E_W  execute control
- W_control  in  W_W  writeback control
- Mem_control  in  1  memory control
- out_valid  out  1  FIFO head valid
- out_ready  in  1  reader accepts head
- out_data  out  REC_W  head record; REC_W = INSTR_W+NPC_W+E_W+W_W+1
- level  out  clog2(DEPTH)+1  current occupancy
- drop_count  out  OVF_W  records dropped on full, saturating
- frozen  out  1  1 in FROZEN state

Behaviour:
- Reset is synchronous and active-high; clock is the single clock. While reset is sampled high:
  - state=HOLDOFF, holdoff counter=0
  - FIFO empty: out_valid=0, out_data=0, level=0
  - drop_count=0, frozen=0
  - last-record register invalid
- Record packing, LSB first: instr_dout[INSTR_W-1:0], then npc_in, then E_control, then W_control, then Mem_control at the MSB. Bench and RTL share this order.
- State HOLDOFF:
  - The counter increments each cycle after reset deasserts.
  - Transition to RUN when counter==HOLDOFF-1, so the first sampling edge is HOLDOFF+1 cycles after reset deasserts.
  - Inputs are ignored in this state.
  - HOLDOFF=0 means the state goes to RUN on the first cycle out of reset.
- State RUN, capture attempt when sample_en=1 and (change_only=0, or last-record invalid, or record != last record):
  - If not full, or a pop happens in the same cycle: push the record and update the last-record register.
  - Else the record is dropped: drop_count increments, saturating at all-ones. If STOP_ON_FULL=1, transition to FROZEN next cycle.
  - A dropped record does not update the last-record register.
- State FROZEN: no pushes and no drop counting; pops continue; frozen=1.
- clear:
  - From RUN or FROZEN: empty the FIFO, zero drop_count, invalidate the last-record register, go to RUN. A same-cycle sample is discarded.
  - Ignored in HOLDOFF.
- FIFO behaviour:
  - Pop when out_valid && out_ready; out_data is the registered head.
  - Push-to-out_valid latency is 1 cycle when empty; no bypass.
  - Simultaneous push and pop when full: both occur and level is unchanged.
  - Simultaneous push and pop when empty: push only, since out_valid=0.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - level = wr-rd with an extra wrap bit.
- out_data holds its value while out_valid=1 and out_ready=0. Its value when out_valid=0 is don't-care, but 0 after reset.
- Reset mid-operation: a one-cycle reset returns every output to its reset value on the next edge, and the holdoff restarts.

Decomposition:
- decode_trace_pkg holds:
  - typedef state_t {HOLDOFF, RUN, FROZEN}
  - the packed struct decode_rec_t for the default widths, matching the packing order above
  - function rec_width(), used by the verification side
- One sub-module: trace_fifo, a parametrised WIDTH/DEPTH sync FIFO with push, pop, full, empty and level. The capture FSM, change filter and drop counter stay in the top.

Test Plan:
- Holdoff: deassert reset, sample_en=1, instr_dout=16'h1234 constant -> out_valid first rises on edge HOLDOFF+2 (9); level=0 before.
- Packing/order: instr=16'hA5A5, npc=16'h3001, E=6'h2A, W=2'b10, Mem=1 -> out_data = {1,2'b10,6'h2A,16'h3001,16'hA5A5}; the npc and instr fields are not swapped.
- change_only=1: feed 16'h1000, 16'h1000, 16'h1000, 16'h2000, others constant -> exactly 2 records captured, level=2.
- Overflow, STOP_ON_FULL=0, DEPTH=8, out_ready=0, 12 distinct samples -> level=8, drop_count=4, frozen=0, FIFO holds the first 8 in order.
- Overflow, STOP_ON_FULL=1, same stimulus -> frozen=1 after the 9th sample, drop_count=1. A clear pulse then gives level=0, drop_count=0, frozen=0, and capture resumes.
- Full with simultaneous push/pop: out_ready=1 with FIFO full and sample_en=1 -> level stays 8, drop_count unchanged, pop order matches push order across pointer wrap.
